// File: rtl/lat_cmd_sequencer.sv
// LAT command sequencer for daisy-chained TLC5957-class drivers: times LAT against SCLK
// posedges and indexes shifter data bits. Optional build macro: FC_ON_RESET_EN.
module lat_cmd_sequencer #(
    parameter int N_DRIVERS   = 1,
    parameter int FCWRTEN_LEN = 15,
    parameter int CW          = $clog2(FCWRTEN_LEN + 48*N_DRIVERS + 2)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              SCLK,
    input  logic                              start,
    input  logic [2:0]                        cmd,
    output logic                              en,
    output logic                              LAT,
    output logic                              data_valid,
    output logic [$clog2(48*N_DRIVERS)-1:0]   bit_idx,
    output logic                              done,
    output logic                              err
);
    localparam int FRAME_LEN = 48*N_DRIVERS;
    localparam int BW        = $clog2(FRAME_LEN);
    localparam logic [2:0] CMD_WRTGS = 3'd0;
    localparam logic [2:0] CMD_WRTFC = 3'd2;

    generate
        if (FRAME_LEN < 13 || (FCWRTEN_LEN + FRAME_LEN + 1) >= (1 << CW)) begin : g_bad_cfg
            $error("lat_cmd_sequencer: FRAME_LEN < 13 or counter width too small");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      cmd_q, cmd_d;
    logic            sclk_q, sclk_rise, cmd_ok;
    logic            done_d, err_d;
    logic [CW-1:0]   lat_len, p_len, data_hi, end_cnt, lat_lo;

    always_comb begin
        case (cmd_q)
            3'd0:    lat_len = CW'(1);
            3'd1:    lat_len = CW'(3);
            3'd2:    lat_len = CW'(5);
            3'd3:    lat_len = CW'(7);
            3'd4:    lat_len = CW'(11);
            3'd5:    lat_len = CW'(13);
            default: lat_len = CW'(1);
        endcase
    end

    // Window boundaries all derive from the latched command, never the live input.
    assign p_len     = (cmd_q == CMD_WRTFC) ? CW'(FCWRTEN_LEN) : '0;
    assign data_hi   = p_len + CW'(FRAME_LEN);
    assign end_cnt   = data_hi + CW'(1);
    assign lat_lo    = data_hi - lat_len + CW'(1);
    assign sclk_rise = SCLK & ~sclk_q;
    assign cmd_ok    = (cmd <= 3'd5);

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef FC_ON_RESET_EN
            state_q <= RUN;
            cmd_q   <= CMD_WRTFC;
`else
            state_q <= IDLE;
            cmd_q   <= CMD_WRTGS;
`endif
        end else begin
            sclk_q  <= SCLK;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (start && cmd_ok) begin
            // A valid start always wins, even over the final posedge of a running op.
            state_d = RUN;
            cnt_d   = '0;
            cmd_d   = cmd;
        end else begin
            err_d = start;
            if (state_q == RUN && sclk_rise) begin
                if (cnt_q == end_cnt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    assign en         = (state_q == RUN);
    assign LAT        = en & (((cnt_q >= CW'(1)) && (cnt_q <= p_len)) ||
                              ((cnt_q >= lat_lo) && (cnt_q <= data_hi)));
    assign data_valid = en && (cnt_q > p_len) && (cnt_q <= data_hi);
    assign bit_idx    = data_valid ? BW'(cnt_q - p_len - CW'(1)) : '0;

endmodule

// File: tb/tb_lat_cmd_sequencer.sv
// Directed bench for lat_cmd_sequencer: one N_DRIVERS=1 and one N_DRIVERS=2 instance
// share the same stimulus; expected windows are hand-derived per command.
module tb_lat_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst, SCLK, start;
    logic [2:0] cmd;
    logic       en1, lat1, dv1, done1, err1;
    logic [5:0] bi1;
    logic       en2, lat2, dv2, done2, err2;
    logic [6:0] bi2;
    int         nvec = 0;
    int         nerr = 0;

`ifdef FC_ON_RESET_EN
    localparam logic FC_RST = 1'b1;
`else
    localparam logic FC_RST = 1'b0;
`endif

    lat_cmd_sequencer #(.N_DRIVERS(1)) dut1 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .start(start), .cmd(cmd),
        .en(en1), .LAT(lat1), .data_valid(dv1), .bit_idx(bi1), .done(done1), .err(err1)
    );

    lat_cmd_sequencer #(.N_DRIVERS(2)) dut2 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .start(start), .cmd(cmd),
        .en(en2), .LAT(lat2), .data_valid(dv2), .bit_idx(bi2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCLK period; returns at the negedge just after the detected rising edge.
    task automatic tick();
        @(negedge clk) SCLK = 1'b1;
        @(negedge clk) SCLK = 1'b0;
    endtask

    task automatic go(input logic [2:0] c);
        @(negedge clk) begin start = 1'b1; cmd = c; end
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; SCLK = 1'b0; start = 1'b0; cmd = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_en",   en1,  FC_RST);
        chk("rst_lat",  lat1, 0);
        chk("rst_dv",   dv1,  0);
        chk("rst_bi",   bi1,  0);
        chk("rst_done", done1, 0);
        chk("rst_err",  err1, 0);
        rst = 1'b0;

        // WRTFC, N=1: prefix 1..15, data 16..63, LAT 59..63, END=64
        go(3'd2);
        chk("wrtfc_en0",  en1,  1);
        chk("wrtfc_lat0", lat1, 0);
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk("wrtfc_lat",  lat1, (k <= 15) || (k >= 59 && k <= 63));
            chk("wrtfc_dv",   dv1,  (k >= 16 && k <= 63));
            chk("wrtfc_bi",   bi1,  (k >= 16 && k <= 63) ? k - 16 : 0);
            chk("wrtfc_en",   en1,  1);
            chk("wrtfc_done", done1, 0);
        end
        tick();
        chk("wrtfc_end_en",   en1,   0);
        chk("wrtfc_end_done", done1, 1);
        @(negedge clk);
        chk("wrtfc_done_1clk", done1, 0);
        chk("wrtfc_idle_lat",  lat1,  0);

        // LATGS, N=1: LAT 46..48, END=49
        go(3'd1);
        for (int k = 1; k <= 49; k++) begin
            tick();
            chk("latgs_lat", lat1, (k >= 46 && k <= 48));
            chk("latgs_en",  en1,  1);
        end
        tick();
        chk("latgs_end_en",   en1,   0);
        chk("latgs_end_done", done1, 1);

        // WRTGS, N=2: LAT only at 96, data 1..96, END=97
        go(3'd0);
        for (int k = 1; k <= 97; k++) begin
            tick();
            chk("wrtgs2_lat",  lat2,  (k == 96));
            chk("wrtgs2_dv",   dv2,   (k <= 96));
            chk("wrtgs2_bi",   bi2,   (k <= 96) ? k - 1 : 0);
            chk("wrtgs2_done", done2, 0);
        end
        tick();
        chk("wrtgs2_end_en",   en2,   0);
        chk("wrtgs2_end_done", done2, 1);

        // LINERESET aborted at counter 20 by TMGRST, N=2: LAT 84..96
        go(3'd3);
        repeat (20) tick();
        chk("abort_pre_lat", lat2, 0);
        chk("abort_pre_dv",  dv2,  1);
        go(3'd5);
        chk("abort_en",   en2,   1);
        chk("abort_done", done2, 0);
        chk("abort_lat",  lat2,  0);
        chk("abort_dv",   dv2,   0);
        for (int k = 1; k <= 97; k++) begin
            tick();
            chk("tmgrst_lat",  lat2,  (k >= 84 && k <= 96));
            chk("tmgrst_done", done2, 0);
        end
        tick();
        chk("tmgrst_end_done", done2, 1);
        chk("tmgrst_end_en",   en2,   0);

        // Invalid cmd mid-op: err pulse, op unchanged
        go(3'd0);
        repeat (10) tick();
        @(negedge clk) begin start = 1'b1; cmd = 3'd7; end
        @(negedge clk) start = 1'b0;
        chk("inv_err",  err1, 1);
        chk("inv_err2", err2, 1);
        chk("inv_en",   en1,  1);
        chk("inv_bi",   bi1,  9);
        @(negedge clk);
        chk("inv_err_1clk", err1, 0);
        for (int k = 11; k <= 49; k++) begin
            tick();
            chk("inv_lat", lat1, (k == 48));
            chk("inv_en",  en1,  1);
        end
        tick();
        chk("inv_end_done", done1, 1);
        chk("inv_end_en",   en1,   0);

        // Start coinciding with the final posedge: restart, no done
        go(3'd1);
        repeat (49) tick();
        chk("coll_pre_en", en1, 1);
        @(negedge clk) begin SCLK = 1'b1; start = 1'b1; cmd = 3'd1; end
        @(negedge clk) begin SCLK = 1'b0; start = 1'b0; end
        chk("coll_done", done1, 0);
        chk("coll_en",   en1,   1);
        chk("coll_lat",  lat1,  0);
        repeat (46) tick();
        chk("coll_lat46", lat1, 1);
        chk("coll_en46",  en1,  1);

        // Reset mid-operation at counter 30
        go(3'd2);
        repeat (30) tick();
        chk("rmid_dv", dv1, 1);
        chk("rmid_bi", bi1, 14);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rmid_en",   en1,   FC_RST);
        chk("rmid_lat",  lat1,  0);
        chk("rmid_dv0",  dv1,   0);
        chk("rmid_bi0",  bi1,   0);
        chk("rmid_done", done1, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
